// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the decode stage and the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic [7:0]       flags;

    modport master (
        output in_valid, alu_ctl, a, b, out_ready,
        input  in_ready, out_valid, z, flags
    );

    modport slave (
        input  in_valid, alu_ctl, a, b, out_ready,
        output in_ready, out_valid, z, flags
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: one-cycle add/sub/rotate/logic, iterative shift-add multiply.
// flags = {Q,L,R,M,N,Z,C,V}
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus,
    output logic     busy
);
    localparam int HALF = WIDTH / 2;
    localparam int RW   = $clog2(WIDTH);
    localparam int CW   = $clog2(HALF + 1);
    localparam int MSB  = WIDTH - 1;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] z_q;
    logic [7:0]       flags_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] acc_q;
    logic [HALF-1:0]  mcand_q;
    logic [HALF-1:0]  mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             eq_q;
    logic             lt_q;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   dif_w;
    logic [RW:0]      rot_k_w;
    logic [RW:0]      rot_kc_w;
    logic [WIDTH-1:0] rotl_w;
    logic [WIDTH-1:0] rotr_w;
    logic             eq_w;
    logic             lt_w;
    logic             mbig_w;
    logic             rbig_w;
    logic [WIDTH-1:0] res_d;
    logic [7:0]       flags_d;
    logic             in_ready_w;
    logic             accept_w;
    logic             iter_mul_w;

    logic [CW-1:0]    shamt_w;
    logic [WIDTH-1:0] addend_w;
    logic [WIDTH-1:0] acc_d;

    // Single-cycle result and flag generation from the presented operands
    always_comb begin
        sum_w    = {1'b0, bus.a} + {1'b0, bus.b};
        dif_w    = {1'b0, bus.a} - {1'b0, bus.b};
        // rotate amount folded modulo WIDTH so non-power-of-two widths still rotate
        rot_k_w  = {1'b0, bus.b[RW-1:0]} % (RW + 1)'(WIDTH);
        rot_kc_w = (RW + 1)'(WIDTH) - rot_k_w;
        rotl_w   = (bus.a << rot_k_w) | (bus.a >> rot_kc_w);
        rotr_w   = (bus.a >> rot_k_w) | (bus.a << rot_kc_w);
        eq_w     = (bus.a == bus.b);
        lt_w     = ($signed(bus.a) < $signed(bus.b));
        mbig_w   = (|bus.a[WIDTH-1:HALF]) | (|bus.b[WIDTH-1:HALF]);
        rbig_w   = |bus.b[WIDTH-1:RW];
        res_d    = '0;
        flags_d  = '0;
        casez (bus.alu_ctl)
            4'b0000: begin
                res_d      = sum_w[WIDTH-1:0];
                flags_d[1] = sum_w[WIDTH];
                flags_d[0] = (bus.a[MSB] == bus.b[MSB]) & (sum_w[MSB] != bus.a[MSB]);
                flags_d[3] = sum_w[MSB];
            end
            4'b0001: begin
                res_d      = dif_w[WIDTH-1:0];
                flags_d[1] = dif_w[WIDTH];
                flags_d[0] = (bus.a[MSB] != bus.b[MSB]) & (dif_w[MSB] != bus.a[MSB]);
                flags_d[3] = dif_w[MSB];
            end
            4'b0010: begin
                flags_d[4] = mbig_w;
            end
            4'b01??: begin
                if (!rbig_w) begin
                    res_d = bus.alu_ctl[1] ? rotl_w : rotr_w;
                end
                flags_d[5] = rbig_w;
                flags_d[3] = res_d[MSB];
            end
            4'b1???: begin
                case (bus.alu_ctl[2:1])
                    2'b00:   res_d = bus.a & bus.b;
                    2'b01:   res_d = bus.a | bus.b;
                    2'b10:   res_d = ~(bus.a & bus.b);
                    default: res_d = bus.a ^ bus.b;
                endcase
            end
            default: ;
        endcase
        if (bus.alu_ctl != 4'b0011) begin
            flags_d[7] = eq_w;
            flags_d[6] = lt_w;
            flags_d[2] = (res_d == '0);
        end
    end

    // Handshake qualification
    always_comb begin
        in_ready_w = (state_q == IDLE) & (~out_valid_q | bus.out_ready);
        accept_w   = bus.in_valid & in_ready_w;
        iter_mul_w = (bus.alu_ctl == 4'b0010) & ~mbig_w;
    end

    // One shift-add iteration of the multiply engine
    always_comb begin
        shamt_w  = CW'(HALF) - cnt_q;
        addend_w = mplier_q[0] ? ({{HALF{1'b0}}, mcand_q} << shamt_w) : '0;
        acc_d    = acc_q + addend_w;
    end

    // Control FSM with registered result, flags and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            z_q         <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                    if (accept_w) begin
                        if (iter_mul_w) begin
                            acc_q    <= '0;
                            mcand_q  <= bus.a[HALF-1:0];
                            mplier_q <= bus.b[HALF-1:0];
                            cnt_q    <= CW'(HALF);
                            eq_q     <= eq_w;
                            lt_q     <= lt_w;
                            busy_q   <= 1'b1;
                            state_q  <= MUL;
                        end else begin
                            z_q         <= res_d;
                            flags_q     <= flags_d;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        z_q         <= acc_d;
                        flags_q     <= {eq_q, lt_q, 3'b000, (acc_d == '0), 2'b00};
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.z         = z_q;
    assign bus.flags     = flags_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8: directed cases plus random traffic
// compared every cycle against an arithmetic model of the expected results.
module tb_alu_seq;
    localparam int W    = 8;
    localparam int HALF = W / 2;

    logic clk;
    logic rst_n;
    logic busy;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nchk  = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected {z, flags} from plain integer arithmetic; iter marks a multi-cycle multiply
    function automatic logic [15:0] model(input logic [3:0] ctl, input int unsigned a,
                                          input int unsigned b, output bit iter);
        int sa, sb, amt, s;
        int unsigned zz;
        bit q, l, r, m, n, c, v;
        sa = (a >= 128) ? int'(a) - 256 : int'(a);
        sb = (b >= 128) ? int'(b) - 256 : int'(b);
        q = (a == b);
        l = (sa < sb);
        r = 0; m = 0; n = 0; c = 0; v = 0; zz = 0; iter = 0;
        if (ctl == 4'b0011) return 16'h0000;
        if (ctl[3]) begin
            case (ctl[2:1])
                2'b00:   zz = a & b;
                2'b01:   zz = a | b;
                2'b10:   zz = ~(a & b) & 255;
                default: zz = a ^ b;
            endcase
        end else if (ctl[2]) begin
            amt = int'(b % 8);
            r = (b >= 8);
            if (r) zz = 0;
            else if (ctl[1]) zz = ((a << amt) | (a >> (8 - amt))) & 255;
            else zz = ((a >> amt) | (a << (8 - amt))) & 255;
            n = (zz >= 128);
        end else if (ctl[1]) begin
            m = (a >= 16) || (b >= 16);
            zz = m ? 0 : a * b;
            iter = !m;
        end else if (!ctl[0]) begin
            zz = a + b;
            c = (zz > 255);
            zz = zz & 255;
            s = sa + sb;
            v = (s > 127) || (s < -128);
            n = (zz >= 128);
        end else begin
            c = (a < b);
            zz = (a - b) & 255;
            s = sa - sb;
            v = (s > 127) || (s < -128);
            n = (zz >= 128);
        end
        return {zz[7:0], q, l, r, m, n, (zz == 0), c, v};
    endfunction

    typedef struct {
        logic [7:0] z;
        logic [7:0] f;
        int         rdy;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          ncyc = 0;
    bit          ovx, bsx, irx, itx;
    logic [15:0] mr;

    // Per-cycle comparison of the DUT against the model's pending result queue
    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
            chk("rst_z", 32'(bus.z), 32'h0);
            chk("rst_flags", 32'(bus.flags), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
        end else begin
            ovx = (q.size() > 0) && (ncyc >= q[0].rdy);
            bsx = (q.size() > 0) && (ncyc < q[0].rdy);
            irx = !bsx && (!ovx || bus.out_ready);
            chk("out_valid", 32'(bus.out_valid), 32'(ovx));
            chk("busy", 32'(busy), 32'(bsx));
            chk("in_ready", 32'(bus.in_ready), 32'(irx));
            if (ovx) begin
                chk("z", 32'(bus.z), 32'(q[0].z));
                chk("flags", 32'(bus.flags), 32'(q[0].f));
            end
            if (ovx && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && irx) begin
                mr    = model(bus.alu_ctl, int'(bus.a), int'(bus.b), itx);
                e.z   = mr[15:8];
                e.f   = mr[7:0];
                e.rdy = ncyc + (itx ? HALF + 1 : 1);
                q.push_back(e);
            end
        end
    end

    task automatic issue(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y,
                         output int tries);
        bit acc;
        bus.in_valid = 1'b1;
        bus.alu_ctl  = c;
        bus.a        = x;
        bus.b        = y;
        tries        = 0;
        acc          = 1'b0;
        while (!acc && tries < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!acc) chk("accept_timeout", 32'(tries), 32'h0);
        bus.in_valid = 1'b0;
    endtask

    // Wait nwait falling edges, check a literal result, then realign to just after a rising edge
    task automatic lit(input string nm, input int nwait, input logic [7:0] ez, input logic [7:0] ef);
        repeat (nwait) @(negedge clk);
        chk({nm, "_valid"}, 32'(bus.out_valid), 32'h1);
        chk({nm, "_z"}, 32'(bus.z), 32'(ez));
        chk({nm, "_flags"}, 32'(bus.flags), 32'(ef));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t;
        bit  it;
        logic [3:0] c;
        logic [7:0] x, y;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_ctl   = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        chk("pin_add", 32'(model(4'b0000, 32'h7F, 32'h01, it)), 32'h8009);
        chk("pin_sub", 32'(model(4'b0001, 32'h03, 32'h05, it)), 32'hFE4A);
        chk("pin_mul", 32'(model(4'b0010, 32'h0F, 32'h0F, it)), 32'hE180);
        chk("pin_mulbig", 32'(model(4'b0010, 32'h1F, 32'h02, it)), 32'h0014);
        chk("pin_rotr", 32'(model(4'b0100, 32'h01, 32'h03, it)), 32'h2040);
        chk("pin_nand", 32'(model(4'b1100, 32'hF0, 32'hCC, it)), 32'h3F00);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(4'b0000, 8'h7F, 8'h01, t);
        lit("add_ovf", 1, 8'h80, 8'h09);

        issue(4'b0001, 8'h03, 8'h05, t);
        issue(4'b0001, 8'h05, 8'h05, t);
        chk("b2b_accept_tries", 32'(t), 32'h1);
        lit("sub_eq", 1, 8'h00, 8'h84);

        issue(4'b0010, 8'h0F, 8'h0F, t);
        lit("mul", HALF + 1, 8'hE1, 8'h80);
        issue(4'b0010, 8'h1F, 8'h02, t);
        lit("mul_big", 1, 8'h00, 8'h14);

        issue(4'b0110, 8'h81, 8'h01, t);
        lit("rotl", 1, 8'h03, 8'h40);
        issue(4'b0100, 8'h01, 8'h03, t);
        lit("rotr", 1, 8'h20, 8'h40);
        issue(4'b0110, 8'h81, 8'h09, t);
        lit("rot_big", 1, 8'h00, 8'h64);

        issue(4'b1100, 8'hF0, 8'hCC, t);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.alu_ctl   = 4'b0000;
        bus.a         = 8'h11;
        bus.b         = 8'h22;
        repeat (3) begin
            @(negedge clk);
            chk("stall_z", 32'(bus.z), 32'h3F);
            chk("stall_in_ready", 32'(bus.in_ready), 32'h0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        issue(4'b0000, 8'h11, 8'h22, t);
        chk("stall_resume_tries", 32'(t), 32'h1);
        lit("after_stall", 1, 8'h33, 8'h40);

        issue(4'b0010, 8'h0F, 8'h0F, t);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midmul_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("midmul_rst_z", 32'(bus.z), 32'h0);
        chk("midmul_rst_flags", 32'(bus.flags), 32'h0);
        chk("midmul_rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(4'b0000, 8'h10, 8'h20, t);
        lit("post_rst", 1, 8'h30, 8'h40);

        for (int i = 0; i < 3000; i++) begin
            c = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) c = 4'b0010;
            x = 8'($urandom);
            y = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (c == 4'b0010) begin
                    x = x & 8'h0F;
                    y = y & 8'h0F;
                end else if (c[3:2] == 2'b01) begin
                    y = y & 8'h07;
                end
            end
            if ($urandom_range(0, 7) == 0) y = x;
            bus.alu_ctl   = c;
            bus.a         = x;
            bus.b         = y;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (HALF + 4) @(posedge clk);
        #1;
        chk("drain_empty", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
